// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST front-end and model.
package mnist_pkg;

  localparam int IMG_W      = 28;
  localparam int IMG_PIXELS = 784;
  localparam int PIX_W      = 8;
  localparam int CNT_W      = 10;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } loader_state_t;

endpackage

// File: rtl/mnist_pixel_loader.sv
// Pixel-stream front end: binarizes a raster-order grayscale frame into a
// 784-bit image, kicks the model with a one-cycle start, then latches the
// predicted digit when the model's valid rises.
//
// state | meaning
// LOAD  | accepting pixels, shifting binarized bits into the image register
// FIRE  | frame complete, start_out high for this single cycle
// WAIT  | image held stable, waiting for a rising edge on done_in
module mnist_pixel_loader
  import mnist_pkg::*;
#(
  parameter logic [PIX_W-1:0] THRESH = 8'd128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIX_W-1:0]      s_data,
  input  logic                  s_last,
  output logic [IMG_PIXELS-1:0] image_out,
  output logic                  start_out,
  input  logic                  done_in,
  input  logic [3:0]            digit_in,
  output logic [3:0]            digit_out,
  output logic                  result_valid,
  output logic                  frame_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_PIXELS - 1);

  loader_state_t         state;
  logic [CNT_W-1:0]      cnt;
  logic [IMG_PIXELS-1:0] shreg;
  logic                  done_q;
  logic                  bin;
  logic                  accept;

  assign s_ready   = (state == LOAD) && rst;
  assign accept    = s_valid && s_ready;
  assign bin       = (s_data >= THRESH);
  assign image_out = shreg;

  // Loader FSM with registered strobes; done_q tracks done_in every cycle so a
  // level left high from the previous inference never looks like a new edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= LOAD;
      cnt          <= '0;
      shreg        <= '0;
      start_out    <= 1'b0;
      digit_out    <= 4'd0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q       <= done_in;
      start_out    <= 1'b0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            if (cnt == LAST_IDX) begin
              // Full frame: used even without s_last, but flagged.
              shreg     <= {shreg[IMG_PIXELS-2:0], bin};
              cnt       <= '0;
              start_out <= 1'b1;
              frame_err <= ~s_last;
              state     <= FIRE;
            end else if (s_last) begin
              // Short frame: discard and resynchronize on the next pixel.
              shreg     <= '0;
              cnt       <= '0;
              frame_err <= 1'b1;
            end else begin
              shreg <= {shreg[IMG_PIXELS-2:0], bin};
              cnt   <= cnt + 1'b1;
            end
          end
        end
        FIRE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (done_in && !done_q) begin
            digit_out    <= digit_in;
            result_valid <= 1'b1;
            state        <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_pixel_loader.sv
// Self-checking bench for mnist_pixel_loader with a behavioural model-stub.
module tb_mnist_pixel_loader;
  import mnist_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic [7:0]   s_data = 8'd0;
  logic         s_last = 1'b0;
  logic         done_in = 1'b0;
  logic [3:0]   digit_in = 4'd0;
  logic         s_ready;
  logic [783:0] image_out;
  logic         start_out;
  logic [3:0]   digit_out;
  logic         result_valid;
  logic         frame_err;

  mnist_pixel_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .image_out(image_out),
    .start_out(start_out), .done_in(done_in), .digit_in(digit_in),
    .digit_out(digit_out), .result_valid(result_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int ferr_cnt = 0;
  int rv_cnt = 0;
  logic [7:0] pix [784];

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (start_out === 1'b1) start_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
    if (result_valid === 1'b1) rv_cnt++;
  end

  // Reference: pixel p lands at bit 783-p, set when pixel >= 128.
  function automatic logic [783:0] model_img();
    logic [783:0] e;
    e = '0;
    for (int p = 0; p < 784; p++) e[783-p] = (pix[p] >= 8'd128);
    return e;
  endfunction

  // Hand-drawn "7": top bar on rows 4-5, two-pixel diagonal stroke below.
  function automatic logic [27:0] row7(input int r);
    case (r)
      4, 5:   return 28'h03FFFC0;
      6, 7:   return 28'h0000180;
      8, 9:   return 28'h0000300;
      10, 11: return 28'h0000600;
      12, 13: return 28'h0000C00;
      14, 15: return 28'h0001800;
      16, 17: return 28'h0003000;
      18, 19: return 28'h0006000;
      20, 21: return 28'h000C000;
      22, 23: return 28'h0018000;
      default: return 28'h0000000;
    endcase
  endfunction

  task automatic fill_random();
    for (int p = 0; p < 784; p++) pix[p] = 8'($urandom_range(0, 255));
  endtask

  // Streams pixels 0..last_idx; returns #1 after the final handshake edge.
  task automatic load_frame(input int gap_pct, input int last_idx, input bit last_on_end);
    for (int p = 0; p <= last_idx; p++) begin
      @(negedge clk);
      for (int g = 0; g < 4 && $urandom_range(0, 99) < gap_pct; g++) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = pix[p];
      s_last  = (p == last_idx) && (p < 783 || last_on_end);
      checks++;
      if (s_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready pixel %0d got %b want 1", p, s_ready);
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called #1 after the 784th handshake. Offers pixels during WAIT, then acts
  // as the model: drops a stale done_in if present and raises it again.
  task automatic run_inference(input logic [3:0] d, input int lat, input bit keep_done,
                               input logic [783:0] exp_img, input int start_base);
    checks++;
    if (start_out !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL fire_cycle got start=%b ready=%b want start=1 ready=0", start_out, s_ready);
    end
    checks++;
    if (image_out !== exp_img) begin
      errors++;
      $display("FAIL image got %h want %h", image_out, exp_img);
    end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'hFF;
      s_last  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checks++;
      if ({start_out, s_ready, result_valid} !== 3'b000 || image_out !== exp_img) begin
        errors++;
        $display("FAIL wait_hold cycle %0d got start=%b ready=%b rv=%b img_ok=%b want 0 0 0 1",
                 i, start_out, s_ready, result_valid, image_out === exp_img);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (done_in) begin
      done_in = 1'b0;
      @(negedge clk);
    end
    done_in  = 1'b1;
    digit_in = d;
    @(posedge clk);
    #1;
    checks++;
    if (result_valid !== 1'b1 || digit_out !== d || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL completion got rv=%b digit=%0d ready=%b want rv=1 digit=%0d ready=1",
               result_valid, digit_out, s_ready, d);
    end
    @(negedge clk);
    if (!keep_done) done_in = 1'b0;
    digit_in = ~d;
    @(posedge clk);
    #1;
    checks++;
    if (result_valid !== 1'b0 || digit_out !== d) begin
      errors++;
      $display("FAIL result_hold got rv=%b digit=%0d want rv=0 digit=%0d", result_valid, digit_out, d);
    end
    checks++;
    if (start_cnt - start_base !== 1) begin
      errors++;
      $display("FAIL start_pulses got %0d want 1", start_cnt - start_base);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, start_out, result_valid, frame_err, digit_out} !== 8'd0 || image_out !== '0) begin
      errors++;
      $display("FAIL reset_state got ready=%b start=%b rv=%b ferr=%b digit=%0d img_zero=%b want all 0",
               s_ready, start_out, result_valid, frame_err, digit_out, image_out === '0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", s_ready);
    end
  endtask

  task automatic test_label7();
    logic [783:0] img7;
    int base;
    img7 = '0;
    for (int r = 0; r < 28; r++) begin
      logic [27:0] row;
      row = row7(r);
      img7 = {img7[755:0], row};
      for (int c = 0; c < 28; c++) pix[r*28+c] = row[27-c] ? 8'd255 : 8'd0;
    end
    base = start_cnt;
    load_frame(0, 783, 1'b1);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL label7_frame_err got %b want 0", frame_err);
    end
    run_inference(4'd7, 20, 1'b0, img7, base);
  endtask

  task automatic test_threshold();
    int base;
    fill_random();
    pix[0] = 8'd127; pix[1] = 8'd128; pix[782] = 8'd127; pix[783] = 8'd128;
    base = start_cnt;
    load_frame(0, 783, 1'b1);
    checks++;
    if ({image_out[783], image_out[782], image_out[1], image_out[0]} !== 4'b0101) begin
      errors++;
      $display("FAIL thresh_bits got %b want 0101",
               {image_out[783], image_out[782], image_out[1], image_out[0]});
    end
    run_inference(4'($urandom_range(0, 9)), $urandom_range(1, 30), 1'b0, model_img(), base);
  endtask

  // Random gaps, and s_last missing on the final pixel: frame used, flagged.
  task automatic test_backpressure();
    int base;
    fill_random();
    base = start_cnt;
    load_frame(40, 783, 1'b0);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL missing_last_err got %b want 1", frame_err);
    end
    run_inference(4'($urandom_range(0, 9)), $urandom_range(5, 25), 1'b0, model_img(), base);
  endtask

  task automatic test_early_last();
    int base;
    int fbase;
    fill_random();
    base  = start_cnt;
    fbase = ferr_cnt;
    load_frame(10, 100, 1'b1);
    checks++;
    if (frame_err !== 1'b1 || image_out !== '0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_last got ferr=%b img_zero=%b ready=%b want 1 1 1",
               frame_err, image_out === '0, s_ready);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (start_cnt - base !== 0 || ferr_cnt - fbase !== 1) begin
      errors++;
      $display("FAIL early_last_pulses got start=%0d ferr=%0d want 0 1",
               start_cnt - base, ferr_cnt - fbase);
    end
    fill_random();
    base = start_cnt;
    load_frame(0, 783, 1'b1);
    run_inference(4'($urandom_range(0, 9)), 8, 1'b0, model_img(), base);
  endtask

  task automatic test_stale_done();
    int base;
    fill_random();
    base = start_cnt;
    load_frame(0, 783, 1'b1);
    run_inference(4'd3, 5, 1'b1, model_img(), base);
    fill_random();
    base = start_cnt;
    load_frame(5, 783, 1'b1);
    run_inference(4'd9, 12, 1'b0, model_img(), base);
  endtask

  task automatic test_mid_reset();
    int base;
    int rbase;
    fill_random();
    base = start_cnt;
    load_frame(0, 783, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rbase    = rv_cnt;
    rst      = 1'b0;
    done_in  = 1'b1;
    digit_in = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, start_out, digit_out} !== 6'd0 || image_out !== '0) begin
      errors++;
      $display("FAIL mid_reset_state got ready=%b start=%b digit=%0d img_zero=%b want 0 0 0 1",
               s_ready, start_out, digit_out, image_out === '0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (rv_cnt - rbase !== 0 || digit_out !== 4'd0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_after got rv_pulses=%0d digit=%0d ready=%b want 0 0 1",
               rv_cnt - rbase, digit_out, s_ready);
    end
    done_in = 1'b0;
    fill_random();
    base = start_cnt;
    load_frame(20, 783, 1'b1);
    run_inference(4'd2, 15, 1'b0, model_img(), base);
  endtask

  initial begin
    test_reset();
    test_label7();
    test_threshold();
    test_backpressure();
    test_early_last();
    test_stale_done();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
